// File: rtl/stack_alu_core.sv
// Stack-based ALU core: a small LIFO of WIDTH-bit words plus an ALU that
// consumes the top one or two entries. MUL runs as an iterative shift-add
// over WIDTH cycles, during which the core refuses new commands.
module stack_alu_core #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 stackOP,
    input  logic [3:0]                 aluOP,
    input  logic [WIDTH-1:0]           immediate,
    output logic [WIDTH-1:0]           a,
    output logic [WIDTH-1:0]           b,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       Overflow,
    output logic                       error,
    output logic                       busy
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_BINOP = 3'd3;
    localparam logic [2:0] OP_UNOP  = 3'd4;
    localparam logic [2:0] OP_DUP   = 3'd5;
    localparam logic [2:0] OP_SWAP  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOT  = 4'd5;
    localparam logic [3:0] ALU_SHL1 = 4'd6;
    localparam logic [3:0] ALU_SHR1 = 4'd7;
    localparam logic [3:0] ALU_MUL  = 4'd8;
    localparam logic [3:0] ALU_NEG  = 4'd9;

    // Stack storage; entry 0 is the bottom, entry depth-1 the top.
    logic [WIDTH-1:0]   mem [DEPTH];

    logic [DW-1:0]      depth_reg, depth_next;
    logic               error_reg, error_next;
    logic               ovf_reg, ovf_next;
    logic               busy_reg;

    // Multiplier state: accumulator, left-shifting multiplicand, right-shifting multiplier.
    logic [2*WIDTH-1:0] acc_reg, mcand_reg, acc_step;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      cnt_reg;
    logic               mul_start, mul_done;

    logic [AW-1:0]      top_idx, sec_idx, push_idx;
    logic [WIDTH-1:0]   a_val, b_val;
    logic               has1, has2, is_full;

    logic [WIDTH-1:0]   bin_res, un_res;
    logic               add_ovf, sub_ovf, binop_ok, unop_ok, accept, illegal;

    logic               we0, we1;
    logic [AW-1:0]      waddr0, waddr1;
    logic [WIDTH-1:0]   wdata0, wdata1;

    assign top_idx  = AW'(depth_reg - DW'(1));
    assign sec_idx  = AW'(depth_reg - DW'(2));
    assign push_idx = AW'(depth_reg);
    assign has1     = (depth_reg != '0);
    assign has2     = (depth_reg >= DW'(2));
    assign is_full  = (depth_reg == DW'(DEPTH));
    assign a_val    = has1 ? mem[top_idx] : '0;
    assign b_val    = has2 ? mem[sec_idx] : '0;

    assign a         = a_val;
    assign b         = b_val;
    assign depth     = depth_reg;
    assign empty     = !has1;
    assign full      = is_full;
    assign Overflow  = ovf_reg;
    assign error     = error_reg;
    assign busy      = busy_reg;
    assign cmd_ready = !busy_reg;

    assign accept   = cmd_valid && !busy_reg;
    assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign mul_done = busy_reg && (cnt_reg == CW'(WIDTH - 1));

    assign binop_ok = aluOP inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_MUL};
    assign unop_ok  = aluOP inside {ALU_NOT, ALU_SHL1, ALU_SHR1, ALU_NEG};

    // ALU datapath for single-cycle binary and unary operations (A = top, B = second).
    always_comb begin
        bin_res = a_val + b_val;
        un_res  = ~a_val;
        case (aluOP)
            ALU_SUB:  bin_res = a_val - b_val;
            ALU_AND:  bin_res = a_val & b_val;
            ALU_OR:   bin_res = a_val | b_val;
            ALU_XOR:  bin_res = a_val ^ b_val;
            default:  bin_res = a_val + b_val;
        endcase
        case (aluOP)
            ALU_SHL1: un_res = a_val << 1;
            ALU_SHR1: un_res = a_val >> 1;
            ALU_NEG:  un_res = '0 - a_val;
            default:  un_res = ~a_val;
        endcase
        add_ovf = (a_val[WIDTH-1] == b_val[WIDTH-1]) && (bin_res[WIDTH-1] != a_val[WIDTH-1]);
        sub_ovf = (a_val[WIDTH-1] != b_val[WIDTH-1]) && (bin_res[WIDTH-1] != a_val[WIDTH-1]);
    end

    // Command decode: legality, stack write ports and next depth/flags.
    always_comb begin
        depth_next = depth_reg;
        error_next = error_reg;
        ovf_next   = ovf_reg;
        we0        = 1'b0;
        we1        = 1'b0;
        waddr0     = top_idx;
        waddr1     = sec_idx;
        wdata0     = bin_res;
        wdata1     = a_val;
        mul_start  = 1'b0;
        illegal    = 1'b0;
        if (mul_done) begin
            // Product replaces the two operands, which are still in place.
            we0        = 1'b1;
            waddr0     = sec_idx;
            wdata0     = acc_step[WIDTH-1:0];
            depth_next = depth_reg - DW'(1);
            ovf_next   = |acc_step[2*WIDTH-1:WIDTH];
        end else if (accept) begin
            case (stackOP)
                OP_PUSH: begin
                    if (is_full) illegal = 1'b1;
                    else begin
                        we0        = 1'b1;
                        waddr0     = push_idx;
                        wdata0     = immediate;
                        depth_next = depth_reg + DW'(1);
                    end
                end
                OP_POP: begin
                    if (!has1) illegal = 1'b1;
                    else depth_next = depth_reg - DW'(1);
                end
                OP_BINOP: begin
                    if (!has2 || !binop_ok) illegal = 1'b1;
                    else if (aluOP == ALU_MUL) mul_start = 1'b1;
                    else begin
                        we0        = 1'b1;
                        waddr0     = sec_idx;
                        wdata0     = bin_res;
                        depth_next = depth_reg - DW'(1);
                        if (aluOP == ALU_ADD) ovf_next = add_ovf;
                        if (aluOP == ALU_SUB) ovf_next = sub_ovf;
                    end
                end
                OP_UNOP: begin
                    if (!has1 || !unop_ok) illegal = 1'b1;
                    else begin
                        we0    = 1'b1;
                        waddr0 = top_idx;
                        wdata0 = un_res;
                    end
                end
                OP_DUP: begin
                    if (!has1 || is_full) illegal = 1'b1;
                    else begin
                        we0        = 1'b1;
                        waddr0     = push_idx;
                        wdata0     = a_val;
                        depth_next = depth_reg + DW'(1);
                    end
                end
                OP_SWAP: begin
                    if (!has2) illegal = 1'b1;
                    else begin
                        we0    = 1'b1;
                        waddr0 = top_idx;
                        wdata0 = b_val;
                        we1    = 1'b1;
                        waddr1 = sec_idx;
                        wdata1 = a_val;
                    end
                end
                OP_CLEAR: begin
                    depth_next = '0;
                    error_next = 1'b0;
                    ovf_next   = 1'b0;
                end
                default: ;
            endcase
            if (illegal) error_next = 1'b1;
        end
    end

    // Control state and multiplier sequencing; reset aborts any MUL in flight.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            depth_reg  <= '0;
            error_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else begin
            depth_reg <= depth_next;
            error_reg <= error_next;
            ovf_reg   <= ovf_next;
            if (mul_start) begin
                busy_reg   <= 1'b1;
                cnt_reg    <= '0;
                acc_reg    <= '0;
                mcand_reg  <= {{WIDTH{1'b0}}, a_val};
                mplier_reg <= b_val;
            end else if (busy_reg) begin
                acc_reg    <= acc_step;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + CW'(1);
                if (mul_done) busy_reg <= 1'b0;
            end
        end
    end

    // Per-entry storage update from the two write ports (second port only used by SWAP).
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (we0 && waddr0 == AW'(gi))
                    mem[gi] <= wdata0;
                else if (we1 && waddr1 == AW'(gi))
                    mem[gi] <= wdata1;
            end
        end
    endgenerate

endmodule

// File: tb/tb_stack_alu_core.sv
// Directed bench for stack_alu_core at WIDTH=16, DEPTH=4.
module tb_stack_alu_core;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       stackOP = 3'd0;
    logic [3:0]       aluOP = 4'd0;
    logic [WIDTH-1:0] immediate = '0;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       depth;
    logic             empty, full, Overflow, error, busy;

    int errors = 0;
    int checks = 0;

    stack_alu_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .stackOP(stackOP), .aluOP(aluOP), .immediate(immediate),
        .a(a), .b(b), .depth(depth), .empty(empty), .full(full),
        .Overflow(Overflow), .error(error), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // One command: driven at the falling edge, sampled 1 time unit after the rising edge.
    task automatic do_cmd(input logic [2:0] op, input logic [3:0] alu, input logic [WIDTH-1:0] imm);
        @(negedge CLK);
        stackOP = op; aluOP = alu; immediate = imm; cmd_valid = 1'b1;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        $display("cmd op=%0d alu=%0d imm=%h -> a=%h b=%h depth=%0d ovf=%b err=%b busy=%b",
                 op, alu, imm, a, b, depth, Overflow, error, busy);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (depth !== 3'd0) begin errors++; $display("FAIL reset_depth: got %0d want 0", depth); end
        checks++; if (a !== 16'h0 || b !== 16'h0) begin errors++; $display("FAIL reset_ab: got a=%h b=%h want 0 0", a, b); end
        checks++; if ({empty, full, cmd_ready, Overflow, error, busy} !== 6'b101000) begin
            errors++; $display("FAIL reset_flags: got %b want 101000", {empty, full, cmd_ready, Overflow, error, busy}); end
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic test_add();
        do_cmd(3'd7, 4'd0, 16'd0);
        do_cmd(3'd1, 4'd0, 16'd3);
        do_cmd(3'd1, 4'd0, 16'd5);
        do_cmd(3'd3, 4'd0, 16'd0);
        checks++; if (a !== 16'd8) begin errors++; $display("FAIL add_result: got %h want 0008", a); end
        checks++; if (depth !== 3'd1) begin errors++; $display("FAIL add_depth: got %0d want 1", depth); end
        checks++; if (Overflow !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL add_flags: got ovf=%b err=%b want 0 0", Overflow, error); end
    endtask

    task automatic test_overflow();
        do_cmd(3'd7, 4'd0, 16'd0);
        do_cmd(3'd1, 4'd0, 16'h7FFF);
        do_cmd(3'd1, 4'd0, 16'h0001);
        do_cmd(3'd3, 4'd0, 16'd0);
        checks++; if (a !== 16'h8000) begin errors++; $display("FAIL ovf_add_result: got %h want 8000", a); end
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_add_flag: got %b want 1", Overflow); end
        do_cmd(3'd1, 4'd0, 16'd2);
        do_cmd(3'd1, 4'd0, 16'd3);
        checks++; if (a !== 16'd3 || b !== 16'd2 || depth !== 3'd3) begin
            errors++; $display("FAIL sub_operands: got a=%h b=%h depth=%0d want 0003 0002 3", a, b, depth); end
        do_cmd(3'd3, 4'd1, 16'd0);
        checks++; if (a !== 16'd1 || b !== 16'h8000 || depth !== 3'd2) begin
            errors++; $display("FAIL sub_result: got a=%h b=%h depth=%0d want 0001 8000 2", a, b, depth); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL sub_ovf: got %b want 0", Overflow); end
    endtask

    task automatic test_full();
        do_cmd(3'd7, 4'd0, 16'd0);
        for (int i = 1; i <= 4; i++) do_cmd(3'd1, 4'd0, 16'(i));
        checks++; if (full !== 1'b1 || depth !== 3'd4 || error !== 1'b0) begin
            errors++; $display("FAIL full_state: got full=%b depth=%0d err=%b want 1 4 0", full, depth, error); end
        do_cmd(3'd1, 4'd0, 16'd5);
        checks++; if (a !== 16'd4 || depth !== 3'd4 || error !== 1'b1) begin
            errors++; $display("FAIL push_when_full: got a=%h depth=%0d err=%b want 0004 4 1", a, depth, error); end
        do_cmd(3'd5, 4'd0, 16'd0);
        checks++; if (depth !== 3'd4 || a !== 16'd4 || b !== 16'd3) begin
            errors++; $display("FAIL dup_when_full: got depth=%0d a=%h b=%h want 4 0004 0003", depth, a, b); end
        do_cmd(3'd7, 4'd0, 16'd0);
        checks++; if (depth !== 3'd0 || error !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL clear: got depth=%0d err=%b empty=%b want 0 0 1", depth, error, empty); end
    endtask

    task automatic test_mul();
        int bad;
        do_cmd(3'd7, 4'd0, 16'd0);
        do_cmd(3'd1, 4'd0, 16'd300);
        do_cmd(3'd1, 4'd0, 16'd300);
        do_cmd(3'd3, 4'd8, 16'd0);
        // Hold a PUSH on the bus for the whole MUL; it must not be taken.
        stackOP = 3'd1; aluOP = 4'd0; immediate = 16'hAAAA; cmd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin @(posedge CLK); #1; end
            if (busy !== 1'b1 || cmd_ready !== 1'b0 || depth !== 3'd2 || a !== 16'd300 || b !== 16'd300) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mul_busy_window: got %0d bad cycles want 0", bad); end
        @(negedge CLK);
        cmd_valid = 1'b0;
        @(posedge CLK);
        #1;
        $display("mul done -> a=%h depth=%0d ovf=%b busy=%b", a, depth, Overflow, busy);
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mul_busy_fall: got busy=%b ready=%b want 0 1", busy, cmd_ready); end
        checks++; if (a !== 16'h5F90 || depth !== 3'd1) begin errors++; $display("FAIL mul_result: got a=%h depth=%0d want 5f90 1", a, depth); end
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL mul_ovf: got %b want 1", Overflow); end
    endtask

    task automatic test_unop_swap_dup();
        do_cmd(3'd1, 4'd0, 16'h00F0);
        do_cmd(3'd4, 4'd5, 16'd0);
        checks++; if (a !== 16'hFF0F) begin errors++; $display("FAIL unop_not: got %h want ff0f", a); end
        do_cmd(3'd4, 4'd6, 16'd0);
        checks++; if (a !== 16'hFE1E) begin errors++; $display("FAIL unop_shl1: got %h want fe1e", a); end
        do_cmd(3'd4, 4'd7, 16'd0);
        checks++; if (a !== 16'h7F0F) begin errors++; $display("FAIL unop_shr1: got %h want 7f0f", a); end
        do_cmd(3'd4, 4'd9, 16'd0);
        checks++; if (a !== 16'h80F1 || depth !== 3'd2 || Overflow !== 1'b1) begin
            errors++; $display("FAIL unop_neg: got a=%h depth=%0d ovf=%b want 80f1 2 1", a, depth, Overflow); end
        do_cmd(3'd6, 4'd0, 16'd0);
        checks++; if (a !== 16'h5F90 || b !== 16'h80F1) begin errors++; $display("FAIL swap: got a=%h b=%h want 5f90 80f1", a, b); end
        do_cmd(3'd5, 4'd0, 16'd0);
        checks++; if (a !== 16'h5F90 || b !== 16'h5F90 || depth !== 3'd3) begin
            errors++; $display("FAIL dup: got a=%h b=%h depth=%0d want 5f90 5f90 3", a, b, depth); end
        do_cmd(3'd3, 4'd4, 16'd0);
        checks++; if (a !== 16'h0000 || b !== 16'h80F1 || depth !== 3'd2 || Overflow !== 1'b1) begin
            errors++; $display("FAIL xor: got a=%h b=%h depth=%0d ovf=%b want 0000 80f1 2 1", a, b, depth, Overflow); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL no_error_yet: got %b want 0", error); end
    endtask

    task automatic test_illegal_alu();
        do_cmd(3'd3, 4'd5, 16'd0);
        checks++; if (error !== 1'b1 || depth !== 3'd2 || a !== 16'h0000) begin
            errors++; $display("FAIL binop_bad_alu: got err=%b depth=%0d a=%h want 1 2 0000", error, depth, a); end
        do_cmd(3'd7, 4'd0, 16'd0);
        do_cmd(3'd1, 4'd0, 16'h1234);
        do_cmd(3'd4, 4'd12, 16'd0);
        checks++; if (error !== 1'b1 || a !== 16'h1234 || depth !== 3'd1) begin
            errors++; $display("FAIL unop_bad_alu: got err=%b a=%h depth=%0d want 1 1234 1", error, a, depth); end
        do_cmd(3'd7, 4'd0, 16'd0);
        do_cmd(3'd1, 4'd0, 16'h0011);
        do_cmd(3'd6, 4'd0, 16'd0);
        checks++; if (error !== 1'b1 || a !== 16'h0011 || b !== 16'h0 || depth !== 3'd1) begin
            errors++; $display("FAIL swap_depth1: got err=%b a=%h b=%h depth=%0d want 1 0011 0000 1", error, a, b, depth); end
    endtask

    task automatic test_pop_empty();
        do_cmd(3'd7, 4'd0, 16'd0);
        do_cmd(3'd2, 4'd0, 16'd0);
        checks++; if (error !== 1'b1 || depth !== 3'd0) begin errors++; $display("FAIL pop_empty: got err=%b depth=%0d want 1 0", error, depth); end
        do_cmd(3'd1, 4'd0, 16'd7);
        checks++; if (a !== 16'd7 || depth !== 3'd1 || error !== 1'b1) begin
            errors++; $display("FAIL push_after_err: got a=%h depth=%0d err=%b want 0007 1 1", a, depth, error); end
    endtask

    task automatic test_async_reset();
        do_cmd(3'd1, 4'd0, 16'd2);
        do_cmd(3'd3, 4'd8, 16'd0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_started: got busy=%b want 1", busy); end
        @(posedge CLK);
        #3;
        reset = 1'b1;
        #1;
        $display("async reset mid-MUL -> a=%h b=%h depth=%0d busy=%b", a, b, depth, busy);
        checks++; if (depth !== 3'd0 || a !== 16'h0 || b !== 16'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL async_reset_state: got depth=%0d a=%h b=%h busy=%b want 0 0 0 0", depth, a, b, busy); end
        checks++; if ({empty, full, cmd_ready, Overflow, error} !== 5'b10100) begin
            errors++; $display("FAIL async_reset_flags: got %b want 10100", {empty, full, cmd_ready, Overflow, error}); end
        @(negedge CLK);
        reset = 1'b0;
        do_cmd(3'd1, 4'd0, 16'd9);
        checks++; if (a !== 16'd9 || depth !== 3'd1) begin errors++; $display("FAIL push_after_reset: got a=%h depth=%0d want 0009 1", a, depth); end
        repeat (20) @(posedge CLK);
        #1;
        checks++; if (a !== 16'd9 || depth !== 3'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL no_partial_mul: got a=%h depth=%0d busy=%b want 0009 1 0", a, depth, busy); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_full();
        test_mul();
        test_unop_swap_dup();
        test_illegal_alu();
        test_pop_empty();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_alu_core.md
STACK_ALU_CORE -- requirements
Module: stack_alu_core

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=4).
REQ-002 Parameter DEPTH, default 8, number of stack entries (>=2).
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present this cycle.
REQ-006 cmd_ready  output  1  core can accept a command; equals !busy.
REQ-007 stackOP  input  3  0 NOP, 1 PUSH, 2 POP, 3 BINOP, 4 UNOP, 5 DUP, 6 SWAP, 7 CLEAR.
REQ-008 aluOP  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL1, 7 SHR1, 8 MUL, 9 NEG.
REQ-009 immediate  input  WIDTH  word pushed by PUSH.
REQ-010 a  output  WIDTH  top-of-stack entry; 0 when depth==0.
REQ-011 b  output  WIDTH  second entry; 0 when depth<2.
REQ-012 depth  output  $clog2(DEPTH+1)  current number of entries.
REQ-013 empty / full  output  1 each  depth==0 / depth==DEPTH.
REQ-014 Overflow  output  1  arithmetic overflow of the last ADD, SUB or MUL.
REQ-015 error  output  1  sticky illegal-command flag.
REQ-016 busy  output  1  multi-cycle MUL in progress.

Function
REQ-017 A command executes when cmd_valid && cmd_ready at a rising edge; the new state is visible on the outputs from that edge onward.
REQ-018 PUSH: immediate becomes the top entry; depth+1.
REQ-019 POP: removes the top entry; depth-1.
REQ-020 BINOP (ADD, SUB, AND, OR, XOR, MUL only): A=a, B=b; pops two entries and pushes A op B; SUB = A-B; depth-1.
REQ-021 UNOP (NOT, SHL1, SHR1, NEG only): replaces the top entry with op(a); SHR1 is logical; NEG is two's complement; depth unchanged.
REQ-022 DUP pushes a copy of a; SWAP exchanges a and b; CLEAR sets depth to 0 and clears error and Overflow.
REQ-023 Illegal commands leave the stack, depth and Overflow unchanged, set error to 1, and take one cycle:
- PUSH or DUP when full
- POP, UNOP or DUP when depth<1
- BINOP or SWAP when depth<2
- an aluOP not permitted for the given stackOP (including 10-15)
REQ-024 error stays 1 until reset or CLEAR.
REQ-025 ADD/SUB set Overflow to the signed two's-complement overflow of the result.
REQ-026 All results are truncated to the low WIDTH bits.
REQ-027 AND, OR, XOR and all UNOPs leave Overflow unchanged.
REQ-028 MUL is an unsigned iterative shift-add multiply:
- on acceptance: operands are latched and busy rises
- busy stays high for exactly WIDTH cycles
- on the edge where busy falls: the two operands are replaced by the low WIDTH bits of the product, and Overflow is set to (upper WIDTH bits != 0)
REQ-029 While busy, cmd_ready is 0 and offered commands are neither executed nor queued.
REQ-030 While busy, the stack contents and outputs a, b and depth hold their pre-MUL values.
REQ-031 NOP leaves all state unchanged.

Reset
REQ-032 While reset is high, asynchronously and regardless of CLK:
- depth, a, b, Overflow, error and busy are 0
- empty is 1, full is 0, cmd_ready is 1
REQ-033 Reset during a MUL aborts it; no partial result is written.
REQ-034 Stack storage beyond depth need not be cleared.

Verification (WIDTH=16, DEPTH=4)
REQ-035 PUSH 3, PUSH 5, BINOP ADD -> a=8, depth=1, Overflow=0, error=0.
REQ-036 PUSH 0x7FFF, PUSH 1, BINOP ADD -> a=0x8000, Overflow=1; then PUSH 2, PUSH 3, BINOP SUB -> Overflow=0; the second BINOP's operands are a=3, b=2, so a=1.
REQ-037 Five PUSHes of 1..5 -> full=1 and depth=4 after the fourth; the fifth is ignored; a=4, error=1; CLEAR -> depth=0, error=0.
REQ-038 PUSH 300, PUSH 300, BINOP MUL with cmd_valid held high (NOP) -> busy and !cmd_ready for 16 cycles, no command accepted; then a=0x5F90, depth=1, Overflow=1.
REQ-039 POP on empty -> error=1, depth=0; a following PUSH 7 succeeds with a=7 and error still 1.
REQ-040 Reset asserted asynchronously mid-MUL, between clock edges -> outputs reach their reset values without a clock edge; after release, PUSH 9 gives a=9, depth=1.
